// File: rtl/mpu_load_feeder_pkg.sv
// Shared definitions for the mpu_load feeder: matrix geometry, element type and
// the feeder state encoding.
package mpu_load_feeder_pkg;

    localparam int unsigned M               = 4;
    localparam int unsigned N               = 4;
    localparam int unsigned MBITS           = $clog2(M);
    localparam int unsigned NBITS           = $clog2(N);
    localparam int unsigned MATRIX_REG_BITS = 2;

    typedef logic [31:0] float_sp;

    typedef enum logic [2:0] {
        FEED_IDLE,
        FEED_FILL,
        FEED_REQUEST,
        FEED_STREAM,
        FEED_FINAL
    } load_feed_state_e;

    // A descriptor is usable only if both dimensions are non-zero and fit the array.
    function automatic logic desc_size_ok(input logic [MBITS:0] m, input logic [NBITS:0] n);
        return (m != '0) && (n != '0) && (32'(m) <= M) && (32'(n) <= N);
    endfunction

endpackage

// File: rtl/mpu_load_feeder_if.sv
// Descriptor, element-stream and mpu_load memory-side signals of the feeder.
interface mpu_load_feeder_if;
    import mpu_load_feeder_pkg::*;

    logic                     desc_valid_in;
    logic                     desc_ready_out;
    logic [MBITS:0]           desc_m_in;
    logic [NBITS:0]           desc_n_in;
    logic [MATRIX_REG_BITS:0] desc_addr_in;
    logic                     src_valid_in;
    logic                     src_ready_out;
    float_sp                  src_element_in;
    logic                     load_req_out;
    float_sp                  mem_load_element_out;
    logic [MBITS:0]           mem_m_load_size_out;
    logic [NBITS:0]           mem_n_load_size_out;
    logic [MATRIX_REG_BITS:0] mem_load_addr_out;
    logic                     mem_load_error_in;
    logic                     mem_load_ack_in;
    logic                     busy_out;
    logic                     done_out;
    logic                     error_out;

    modport master (
        output desc_valid_in, desc_m_in, desc_n_in, desc_addr_in,
               src_valid_in, src_element_in, mem_load_error_in, mem_load_ack_in,
        input  desc_ready_out, src_ready_out, load_req_out, mem_load_element_out,
               mem_m_load_size_out, mem_n_load_size_out, mem_load_addr_out,
               busy_out, done_out, error_out
    );

    modport slave (
        input  desc_valid_in, desc_m_in, desc_n_in, desc_addr_in,
               src_valid_in, src_element_in, mem_load_error_in, mem_load_ack_in,
        output desc_ready_out, src_ready_out, load_req_out, mem_load_element_out,
               mem_m_load_size_out, mem_n_load_size_out, mem_load_addr_out,
               busy_out, done_out, error_out
    );

endinterface

// File: rtl/mpu_load_feeder_stage_buffer.sv
// Staging RAM for one matrix: synchronous write, combinational read, array not reset.
module mpu_stage_buffer
    import mpu_load_feeder_pkg::*;
#(
    parameter int unsigned DEPTH     = M * N,
    parameter int unsigned ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 wr_en,
    input  logic [ADDR_BITS-1:0] wr_addr,
    input  float_sp              wr_data,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output float_sp              rd_data
);

    float_sp mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/mpu_load_feeder.sv
// Buffers a whole row-major matrix, then streams it to mpu_load one element per ack.
module mpu_load_feeder
    import mpu_load_feeder_pkg::*;
#(
    parameter int unsigned BUF_DEPTH = M * N,
    parameter int unsigned CNT_BITS  = $clog2(BUF_DEPTH + 1)
) (
    input logic              clk,
    input logic              rst_n,
    mpu_load_feeder_if.slave bus
);

    localparam int unsigned ADDR_BITS = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    load_feed_state_e         state, state_nxt;
    logic [CNT_BITS-1:0]      wr_cnt, wr_cnt_nxt, rd_cnt, rd_cnt_nxt, total;
    logic [MBITS:0]           m_q, m_nxt;
    logic [NBITS:0]           n_q, n_nxt;
    logic [MATRIX_REG_BITS:0] addr_q, addr_nxt;
    float_sp                  elem_q, elem_nxt, rd_data;
    logic                     err_q, err_nxt, active_q;
    logic                     src_ready, wr_en;
    logic [ADDR_BITS-1:0]     rd_addr;

    assign total     = CNT_BITS'(m_q) * CNT_BITS'(n_q);
    assign src_ready = (state == FEED_FILL) && (wr_cnt != total);
    assign wr_en     = src_ready && bus.src_valid_in;

    mpu_stage_buffer #(
        .DEPTH     (BUF_DEPTH),
        .ADDR_BITS (ADDR_BITS)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_cnt[ADDR_BITS-1:0]),
        .wr_data (bus.src_element_in),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_comb begin
        state_nxt  = state;
        wr_cnt_nxt = wr_cnt;
        rd_cnt_nxt = rd_cnt;
        m_nxt      = m_q;
        n_nxt      = n_q;
        addr_nxt   = addr_q;
        elem_nxt   = elem_q;
        err_nxt    = 1'b0;
        rd_addr    = '0;
        case (state)
            FEED_IDLE: begin
                if (bus.desc_valid_in && active_q) begin
                    if (desc_size_ok(bus.desc_m_in, bus.desc_n_in)) begin
                        m_nxt      = bus.desc_m_in;
                        n_nxt      = bus.desc_n_in;
                        addr_nxt   = bus.desc_addr_in;
                        wr_cnt_nxt = '0;
                        state_nxt  = FEED_FILL;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
            end
            FEED_FILL: begin
                if (wr_cnt == total) begin
                    state_nxt = FEED_REQUEST;
                end else if (wr_en) begin
                    wr_cnt_nxt = wr_cnt + CNT_BITS'(1);
                end
            end
            FEED_REQUEST: begin
                if (bus.mem_load_error_in) begin
                    err_nxt   = 1'b1;
                    m_nxt     = '0;
                    n_nxt     = '0;
                    addr_nxt  = '0;
                    state_nxt = FEED_IDLE;
                end else if (bus.mem_load_ack_in) begin
                    elem_nxt   = rd_data;
                    rd_cnt_nxt = CNT_BITS'(1);
                    state_nxt  = FEED_STREAM;
                end
            end
            FEED_STREAM: begin
                // Element leads mpu_load's write by one cycle: buf[rd_cnt] is presented on this ack.
                rd_addr = rd_cnt[ADDR_BITS-1:0];
                if (rd_cnt == total) begin
                    state_nxt = FEED_FINAL;
                end else if (bus.mem_load_ack_in) begin
                    elem_nxt   = rd_data;
                    rd_cnt_nxt = rd_cnt + CNT_BITS'(1);
                end
            end
            FEED_FINAL: begin
                m_nxt      = '0;
                n_nxt      = '0;
                addr_nxt   = '0;
                elem_nxt   = '0;
                wr_cnt_nxt = '0;
                rd_cnt_nxt = '0;
                state_nxt  = FEED_IDLE;
            end
            default: state_nxt = FEED_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FEED_IDLE;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            m_q      <= '0;
            n_q      <= '0;
            addr_q   <= '0;
            elem_q   <= '0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wr_cnt   <= wr_cnt_nxt;
            rd_cnt   <= rd_cnt_nxt;
            m_q      <= m_nxt;
            n_q      <= n_nxt;
            addr_q   <= addr_nxt;
            elem_q   <= elem_nxt;
            err_q    <= err_nxt;
            active_q <= 1'b1;
        end
    end

    assign bus.desc_ready_out       = active_q && (state == FEED_IDLE);
    assign bus.src_ready_out        = src_ready;
    assign bus.load_req_out         = (state == FEED_REQUEST);
    assign bus.mem_load_element_out = elem_q;
    assign bus.mem_m_load_size_out  = m_q;
    assign bus.mem_n_load_size_out  = n_q;
    assign bus.mem_load_addr_out    = addr_q;
    assign bus.busy_out             = (state != FEED_IDLE);
    assign bus.done_out             = (state == FEED_FINAL);
    assign bus.error_out            = err_q;

endmodule

// File: tb/tb_mpu_load_feeder.sv
// Randomised bench for mpu_load_feeder with an mpu_load responder and a per-cycle
// comparison against a transaction-level expectation of the feeder.
module tb_mpu_load_feeder;
    import mpu_load_feeder_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mpu_load_feeder_if bus ();

    mpu_load_feeder #(.BUF_DEPTH(M * N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned checks = 0, passes = 0;
    int unsigned exp_m = 0, exp_n = 0, exp_addr = 0, exp_total = 0, accepted = 0;
    int unsigned wr_idx = 0, since_rst = 0;
    logic        in_xfer = 1'b0, ack_d = 1'b0, prev_done = 1'b0;
    float_sp     sent_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0b, expected %0b", name, act, exp);
    endtask

    // Every cycle: transaction-level rules the outputs must obey, plus the element
    // mpu_load writes in the cycle following each ack.
    task automatic cycle_compare();
        if (!rst_n) begin
            since_rst = 0;
            prev_done = 1'b0;
            wr_idx    = 0;
            return;
        end
        chk1("busy", bus.busy_out, in_xfer);
        if (since_rst > 0) chk1("desc_ready", bus.desc_ready_out, !in_xfer);
        if (in_xfer) begin
            chk("m_size", 32'(bus.mem_m_load_size_out), exp_m);
            chk("n_size", 32'(bus.mem_n_load_size_out), exp_n);
            chk("addr", 32'(bus.mem_load_addr_out), exp_addr);
            if (bus.src_ready_out) chk1("src_ready_room", accepted < exp_total, 1'b1);
            if (bus.load_req_out) chk("req_after_fill", accepted, exp_total);
        end else begin
            chk("idle_outputs", 32'({bus.load_req_out, bus.src_ready_out, bus.done_out,
                                     bus.mem_m_load_size_out, bus.mem_n_load_size_out,
                                     bus.mem_load_addr_out}), 32'd0);
            wr_idx = 0;
        end
        if (ack_d && in_xfer) begin
            if (wr_idx < 32'(sent_q.size())) chk("element", bus.mem_load_element_out, sent_q[wr_idx]);
            else chk("write_count", wr_idx + 1, exp_total);
            wr_idx++;
        end
        if (bus.done_out) chk("done_writes", wr_idx, exp_total);
        chk1("done_pulse", prev_done && bus.done_out, 1'b0);
        prev_done = bus.done_out;
        since_rst++;
    endtask

    task automatic tick();
        @(negedge clk);
        cycle_compare();
        ack_d = bus.mem_load_ack_in && rst_n;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_random(input int unsigned cnt);
        sent_q.delete();
        for (int unsigned i = 0; i < cnt; i++) sent_q.push_back($urandom);
    endtask

    task automatic send_desc(input int unsigned m, input int unsigned n, input int unsigned a);
        int unsigned cyc = 0;
        bit ok;
        ok = (m >= 1) && (m <= M) && (n >= 1) && (n <= N);
        while (!bus.desc_ready_out && cyc < 50) begin
            tick();
            cyc++;
        end
        chk1("desc_ready_wait", bus.desc_ready_out, 1'b1);
        bus.desc_valid_in = 1'b1;
        bus.desc_m_in     = (MBITS + 1)'(m);
        bus.desc_n_in     = (NBITS + 1)'(n);
        bus.desc_addr_in  = (MATRIX_REG_BITS + 1)'(a);
        if (ok) begin
            exp_m     = m;
            exp_n     = n;
            exp_addr  = a;
            exp_total = m * n;
            accepted  = 0;
        end
        tick();
        bus.desc_valid_in = 1'b0;
        chk1("error_pulse", bus.error_out, !ok);
        if (ok) begin
            in_xfer = 1'b1;
        end else begin
            tick();
            chk1("error_clear", bus.error_out, 1'b0);
        end
    endtask

    // gap_mode: 0 continuous, 1 valid toggling 1010..., 2 random valid
    task automatic feed(input int unsigned gap_mode);
        int unsigned cyc = 0;
        bit v, fire;
        while (accepted < exp_total && cyc < 500) begin
            case (gap_mode)
                0:       v = 1'b1;
                1:       v = (cyc % 2 == 0);
                default: v = 1'($urandom_range(0, 1));
            endcase
            bus.src_valid_in   = v;
            bus.src_element_in = sent_q[accepted];
            fire = v && bus.src_ready_out;
            tick();
            cyc++;
            if (fire) accepted++;
        end
        bus.src_valid_in = 1'b0;
        chk("fill_count", accepted, exp_total);
    endtask

    task automatic reset_mid();
        rst_n   = 1'b0;
        in_xfer = 1'b0;
        #1;
        chk("rst_element", bus.mem_load_element_out, 32'd0);
        chk("rst_ctrl", 32'({bus.load_req_out, bus.src_ready_out, bus.desc_ready_out,
                             bus.busy_out, bus.done_out, bus.error_out,
                             bus.mem_m_load_size_out, bus.mem_n_load_size_out,
                             bus.mem_load_addr_out}), 32'd0);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (2) tick();
    endtask

    // mpu_load side: wait for load_req, hold off for delay cycles, then m*n back-to-back acks.
    task automatic respond(input int unsigned delay, input int unsigned abort_after);
        int unsigned cyc = 0;
        while (!bus.load_req_out && cyc < 50) begin
            tick();
            cyc++;
        end
        chk1("req_seen", bus.load_req_out, 1'b1);
        for (int unsigned d = 0; d < delay; d++) begin
            tick();
            chk1("req_hold", bus.load_req_out, 1'b1);
        end
        for (int unsigned k = 0; k < exp_total; k++) begin
            if (abort_after != 0 && k == abort_after) begin
                bus.mem_load_ack_in = 1'b0;
                reset_mid();
                return;
            end
            bus.mem_load_ack_in = 1'b1;
            tick();
            if (k == 0) chk1("req_drop", bus.load_req_out, 1'b0);
        end
        bus.mem_load_ack_in = 1'b0;
        cyc = 0;
        while (!bus.done_out && cyc < 20) begin
            tick();
            cyc++;
        end
        chk1("done_seen", bus.done_out, 1'b1);
        tick();
        in_xfer = 1'b0;
        chk1("idle_after_done", bus.busy_out, 1'b0);
    endtask

    task automatic run_xfer(input int unsigned m, input int unsigned n, input int unsigned a,
                            input int unsigned gap_mode, input int unsigned delay,
                            input int unsigned abort_after);
        send_desc(m, n, a);
        feed(gap_mode);
        respond(delay, abort_after);
    endtask

    initial begin
        int unsigned cyc;
        bus.desc_valid_in     = 1'b0;
        bus.desc_m_in         = '0;
        bus.desc_n_in         = '0;
        bus.desc_addr_in      = '0;
        bus.src_valid_in      = 1'b0;
        bus.src_element_in    = '0;
        bus.mem_load_error_in = 1'b0;
        bus.mem_load_ack_in   = 1'b0;
        #1;
        chk("reset_element", bus.mem_load_element_out, 32'd0);
        chk("reset_ctrl", 32'({bus.load_req_out, bus.src_ready_out, bus.desc_ready_out,
                               bus.busy_out, bus.done_out, bus.error_out,
                               bus.mem_m_load_size_out, bus.mem_n_load_size_out,
                               bus.mem_load_addr_out}), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        chk1("ready_after_reset", bus.desc_ready_out, 1'b1);

        // 2x3 of 1.0 .. 6.0
        sent_q = '{32'h3f80_0000, 32'h4000_0000, 32'h4040_0000,
                   32'h4080_0000, 32'h40a0_0000, 32'h40c0_0000};
        run_xfer(2, 3, 1, 0, 0, 0);
        chk("pin_2x3_writes", wr_idx, 32'd6);

        // 1x1 of 3.5
        sent_q = '{32'h4060_0000};
        run_xfer(1, 1, 2, 0, 2, 0);
        chk("pin_1x1_writes", wr_idx, 32'd1);

        // Rejected descriptors
        send_desc(0, 2, 0);
        send_desc(M + 1, 2, 0);
        send_desc(2, N + 1, 1);
        send_desc(3, 0, 3);

        // 4x4 with a 1010 source pattern, then a 5-cycle ack hold-off
        fill_random(16);
        run_xfer(4, 4, 3, 1, 0, 0);
        fill_random(4);
        run_xfer(2, 2, 5, 0, 5, 0);

        // Reset while streaming after three acks, then a normal transfer
        fill_random(9);
        run_xfer(3, 3, 4, 0, 1, 3);
        fill_random(8);
        run_xfer(2, 4, 6, 2, 0, 0);

        // mpu_load size error while requesting
        fill_random(2);
        send_desc(1, 2, 7);
        feed(0);
        cyc = 0;
        while (!bus.load_req_out && cyc < 50) begin
            tick();
            cyc++;
        end
        chk1("err_req_seen", bus.load_req_out, 1'b1);
        bus.mem_load_error_in = 1'b1;
        tick();
        bus.mem_load_error_in = 1'b0;
        in_xfer = 1'b0;
        chk1("mem_error_pulse", bus.error_out, 1'b1);
        chk1("mem_error_idle", bus.busy_out, 1'b0);
        tick();
        chk1("mem_error_clear", bus.error_out, 1'b0);

        for (int unsigned i = 0; i < 12; i++) begin
            int unsigned m, n;
            m = $urandom_range(1, M);
            n = $urandom_range(1, N);
            fill_random(m * n);
            run_xfer(m, n, $urandom_range(0, 7), $urandom_range(0, 2), $urandom_range(0, 4), 0);
        end

        repeat (3) tick();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
